wb_commit_regfile: RTL

//  Writeback-side consumer of the MEM/WB stage outputs (WBpc/WBinst/WBrf_we/WBrf_wd).

---
 rtl/cpu_defs.sv | 19 +
 rtl/commit_trace_fifo.sv | 57 +++++
 rtl/wb_commit_regfile.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions for the writeback/commit slice.
//   XLEN, register address width, destination-field position in the instruction,
//   the bubble encoding and the commit-trace entry layout.
package cpu_defs;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned RD_LSB      = 7;
    localparam int unsigned RD_MSB      = 11;
    localparam logic [31:0] BUBBLE_INST = 32'h0;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic [XLEN-1:0]       wd;
    } trc_entry_t;

endpackage

// File: rtl/commit_trace_fifo.sv
// Circular FIFO buffering commit-trace entries.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push, din  : write request and data; dropped when full unless popped the same cycle
//   pop        : read request; ignored when empty
//   dout       : head entry, zero while empty
//   full/empty : occupancy flags
module commit_trace_fifo #(
    parameter int unsigned WIDTH = 70,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en, rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the head slot this cycle, so a push into a full FIFO is still taken.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/wb_commit_regfile.sv
// Writeback-stage consumer: integer register file, retire counter and commit trace.
//   clk, rst_n               : clock, async active-low reset
//   WBpc/WBinst/WBrf_we/WBrf_wd : MEM/WB outputs; WBinst == 0 is a bubble
//   rs1_addr/rs2_addr -> rs1_data/rs2_data : combinational reads with same-cycle bypass
//   instret                  : retired-instruction count
//   trc_valid/trc_ready/trc_pc/trc_rd/trc_we/trc_wd : commit-trace stream (head of FIFO)
//   trc_ovf/trc_ovf_clr      : sticky dropped-commit flag and its synchronous clear
module wb_commit_regfile
    import cpu_defs::*;
#(
    parameter int unsigned TRC_DEPTH = 4,
    parameter int unsigned CNT_W     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      WBpc,
    input  logic [31:0]      WBinst,
    input  logic             WBrf_we,
    input  logic [31:0]      WBrf_wd,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [31:0]      rs1_data,
    output logic [31:0]      rs2_data,
    output logic [CNT_W-1:0] instret,
    output logic             trc_valid,
    input  logic             trc_ready,
    output logic [31:0]      trc_pc,
    output logic [4:0]       trc_rd,
    output logic             trc_we,
    output logic [31:0]      trc_wd,
    output logic             trc_ovf,
    input  logic             trc_ovf_clr
);

    logic [XLEN-1:0]       regs_q [32];
    logic [REG_ADDR_W-1:0] rd;
    logic                  commit, rf_wr;
    logic                  fifo_full, fifo_empty, pop, ovf_set;
    logic [CNT_W-1:0]      instret_q;
    logic                  ovf_q, ovf_d;
    trc_entry_t            push_entry, head;

    assign rd     = WBinst[RD_MSB:RD_LSB];
    assign commit = (WBinst != BUBBLE_INST);
    assign rf_wr  = WBrf_we && (rd != '0);

    // Register file; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_wr) begin
            regs_q[rd] <= WBrf_wd;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (WBrf_we && (rd == rs1_addr)) begin
            rs1_data = WBrf_wd;
        end
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (WBrf_we && (rd == rs2_addr)) begin
            rs2_data = WBrf_wd;
        end
    end

    // Retire counter counts every commit, even one whose trace entry is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (commit) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end
    assign instret = instret_q;

    assign push_entry.pc = WBpc;
    assign push_entry.rd = rd;
    assign push_entry.we = rf_wr;
    assign push_entry.wd = WBrf_wd;

    assign pop = !fifo_empty && trc_ready;

    commit_trace_fifo #(
        .WIDTH ($bits(trc_entry_t)),
        .DEPTH (TRC_DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (commit),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign trc_valid = !fifo_empty;
    assign trc_pc    = head.pc;
    assign trc_rd    = head.rd;
    assign trc_we    = head.we;
    assign trc_wd    = head.wd;

    // Clear beats a same-cycle set.
    assign ovf_set = commit && fifo_full && !pop;

    always_comb begin
        ovf_d = ovf_q;
        if (trc_ovf_clr) begin
            ovf_d = 1'b0;
        end else if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign trc_ovf = ovf_q;

endmodule
